// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: ALU op codes,
// forward-select encoding and the layout of the EX slot.
package id_ex_stage_pkg;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_ADDU = 5'b00001;
  localparam logic [4:0] ALU_SUB  = 5'b00010;
  localparam logic [4:0] ALU_SUBU = 5'b00011;
  localparam logic [4:0] ALU_AND  = 5'b00100;
  localparam logic [4:0] ALU_OR   = 5'b00101;
  localparam logic [4:0] ALU_XOR  = 5'b00110;
  localparam logic [4:0] ALU_NOR  = 5'b00111;
  localparam logic [4:0] ALU_SLT  = 5'b01000;
  localparam logic [4:0] ALU_SLTU = 5'b01001;
  localparam logic [4:0] ALU_SLL  = 5'b01010;
  localparam logic [4:0] ALU_SRL  = 5'b01011;
  localparam logic [4:0] ALU_SRA  = 5'b01100;
  localparam logic [4:0] ALU_SLLV = 5'b01101;
  localparam logic [4:0] ALU_SRLV = 5'b01110;
  localparam logic [4:0] ALU_SRAV = 5'b01111;
  localparam logic [4:0] ALU_LUI  = 5'b10000;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_t;

  typedef struct packed {
    logic        valid;
    logic        wreg;
    logic        mem2reg;
    logic        wmem;
    logic [4:0]  aluc;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic        sel_shamt;
    logic        sel_imm;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
  } ex_slot_t;

  // A bubble is all-zero: no write enables and register numbers of r0.
  localparam ex_slot_t EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_fwd_sel.sv
// Operand forwarding for one source register: the EX/MEM result beats the
// MEM/WB result, which beats the value read in decode. r0 is never forwarded.
module fwd_sel
  import id_ex_stage_pkg::*;
(
  input  logic [4:0]  num,
  input  logic [31:0] reg_val,
  input  logic        mem_wreg,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_res,
  input  logic        wb_wreg,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [31:0] val,
  output logic [1:0]  sel
);

  fwd_t sel_e;

  always_comb begin
    sel_e = FWD_REG;
    if (num != 5'd0) begin
      if (mem_wreg && (mem_rd == num))
        sel_e = FWD_MEM;
      else if (wb_wreg && (wb_rd == num))
        sel_e = FWD_WB;
    end
  end

  always_comb begin
    case (sel_e)
      FWD_MEM: val = mem_res;
      FWD_WB:  val = wb_data;
      default: val = reg_val;
    endcase
  end

  assign sel = sel_e;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and EX-side operand forwarding feeding the ALU.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_aluc,
  input  logic [31:0] id_rs_val,
  input  logic [31:0] id_rt_val,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_shamt,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_sel_shamt,
  input  logic        id_sel_imm,
  input  logic        id_wreg,
  input  logic        id_mem2reg,
  input  logic        id_wmem,
  input  logic        mem_wreg,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_res,
  input  logic        wb_wreg,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        stall,
  output logic        ex_valid,
  output logic        ex_wreg,
  output logic        ex_mem2reg,
  output logic        ex_wmem,
  output logic [4:0]  ex_rd,
  output logic [4:0]  alu_aluc,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] ex_store_data
);

  ex_slot_t ex_reg;
  ex_slot_t ex_next;
  logic     rs_hit;
  logic     rt_hit;
  logic     load_use;

  // A load in EX cannot supply its data until MEM, so a dependent decode waits.
  assign rs_hit   = id_use_rs && (id_rs == ex_reg.rd);
  assign rt_hit   = id_use_rt && (id_rt == ex_reg.rd);
  assign load_use = id_valid && ex_reg.valid && ex_reg.mem2reg &&
                    (ex_reg.rd != 5'd0) && (rs_hit || rt_hit);
  assign stall    = load_use && !flush;

  always_comb begin
    ex_next = EX_BUBBLE;
    if (!flush && !load_use && id_valid) begin
      ex_next.valid     = 1'b1;
      ex_next.wreg      = id_wreg;
      ex_next.mem2reg   = id_mem2reg;
      ex_next.wmem      = id_wmem;
      ex_next.aluc      = id_aluc;
      ex_next.rd        = id_rd;
      ex_next.rs        = id_rs;
      ex_next.rt        = id_rt;
      ex_next.shamt     = id_shamt;
      ex_next.sel_shamt = id_sel_shamt;
      ex_next.sel_imm   = id_sel_imm;
      ex_next.rs_val    = id_rs_val;
      ex_next.rt_val    = id_rt_val;
      ex_next.imm       = id_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ex_reg <= EX_BUBBLE;
    else
      ex_reg <= ex_next;
  end

  // Index 0 forwards rs, index 1 forwards rt.
  logic [4:0]  src_num [2];
  logic [31:0] src_val [2];
  logic [31:0] fwd_val [2];
  logic [1:0]  fwd_sel_unused [2];

  assign src_num[0] = ex_reg.rs;
  assign src_num[1] = ex_reg.rt;
  assign src_val[0] = ex_reg.rs_val;
  assign src_val[1] = ex_reg.rt_val;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_sel u_fwd_sel (
        .num      (src_num[gi]),
        .reg_val  (src_val[gi]),
        .mem_wreg (mem_wreg),
        .mem_rd   (mem_rd),
        .mem_res  (mem_res),
        .wb_wreg  (wb_wreg),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .val      (fwd_val[gi]),
        .sel      (fwd_sel_unused[gi])
      );
    end
  endgenerate

  assign ex_valid      = ex_reg.valid;
  assign ex_wreg       = ex_reg.wreg;
  assign ex_mem2reg    = ex_reg.mem2reg;
  assign ex_wmem       = ex_reg.wmem;
  assign ex_rd         = ex_reg.rd;
  assign alu_aluc      = ex_reg.aluc;
  assign alu_a         = ex_reg.sel_shamt ? {27'b0, ex_reg.shamt} : fwd_val[0];
  assign alu_b         = ex_reg.sel_imm ? ex_reg.imm : fwd_val[1];
  assign ex_store_data = fwd_val[1];

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a behavioural EX-slot model checked every
// cycle, plus literal expectations from hand-worked pipeline scenarios.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_aluc;
  logic [31:0] id_rs_val, id_rt_val, id_imm;
  logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
  logic        id_use_rs, id_use_rt, id_sel_shamt, id_sel_imm;
  logic        id_wreg, id_mem2reg, id_wmem;
  logic        mem_wreg;
  logic [4:0]  mem_rd;
  logic [31:0] mem_res;
  logic        wb_wreg;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        stall, ex_valid, ex_wreg, ex_mem2reg, ex_wmem;
  logic [4:0]  ex_rd, alu_aluc;
  logic [31:0] alu_a, alu_b, ex_store_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_aluc(id_aluc),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_sel_shamt(id_sel_shamt), .id_sel_imm(id_sel_imm),
    .id_wreg(id_wreg), .id_mem2reg(id_mem2reg), .id_wmem(id_wmem),
    .mem_wreg(mem_wreg), .mem_rd(mem_rd), .mem_res(mem_res),
    .wb_wreg(wb_wreg), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_wreg(ex_wreg),
    .ex_mem2reg(ex_mem2reg), .ex_wmem(ex_wmem), .ex_rd(ex_rd),
    .alu_aluc(alu_aluc), .alu_a(alu_a), .alu_b(alu_b),
    .ex_store_data(ex_store_data)
  );

  // Model of the instruction occupying EX (all zero for a bubble).
  logic        m_valid, m_wreg, m_m2r, m_wmem, m_selsh, m_selimm;
  logic [4:0]  m_aluc, m_rd, m_rs, m_rt, m_shamt;
  logic [31:0] m_rsv, m_rtv, m_imm;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic exp_stall();
    logic dep;
    dep = (id_use_rs && id_rs == m_rd) || (id_use_rt && id_rt == m_rd);
    return id_valid && m_valid && m_m2r && (m_rd != 5'd0) && dep && !flush;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] n, input logic [31:0] v);
    if (n == 5'd0) return v;
    if (mem_wreg && mem_rd == n) return mem_res;
    if (wb_wreg && wb_rd == n) return wb_data;
    return v;
  endfunction

  always @(posedge clk) begin
    logic take;
    take = !rst && !flush && id_valid && !exp_stall();
    m_valid  = take;
    m_wreg   = take & id_wreg;
    m_m2r    = take & id_mem2reg;
    m_wmem   = take & id_wmem;
    m_selsh  = take & id_sel_shamt;
    m_selimm = take & id_sel_imm;
    m_aluc   = take ? id_aluc   : 5'd0;
    m_rd     = take ? id_rd     : 5'd0;
    m_rs     = take ? id_rs     : 5'd0;
    m_rt     = take ? id_rt     : 5'd0;
    m_shamt  = take ? id_shamt  : 5'd0;
    m_rsv    = take ? id_rs_val : 32'd0;
    m_rtv    = take ? id_rt_val : 32'd0;
    m_imm    = take ? id_imm    : 32'd0;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_stall", stall, exp_stall());
      chk("m_valid", ex_valid, m_valid);
      chk("m_wreg", ex_wreg, m_wreg);
      chk("m_mem2reg", ex_mem2reg, m_m2r);
      chk("m_wmem", ex_wmem, m_wmem);
      chk("m_rd", ex_rd, m_rd);
      chk("m_aluc", alu_aluc, m_aluc);
      chk("m_alu_a", alu_a, m_selsh ? {27'd0, m_shamt} : fwd(m_rs, m_rsv));
      chk("m_alu_b", alu_b, m_selimm ? m_imm : fwd(m_rt, m_rtv));
      chk("m_store", ex_store_data, fwd(m_rt, m_rtv));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc=%0d rst=%b flush=%b stall=%b ex_valid=%b rd=%0d aluc=%b a=%h b=%h sd=%h",
             cyc, rst, flush, stall, ex_valid, ex_rd, alu_aluc, alu_a, alu_b, ex_store_data);
  endtask

  task automatic instr(input logic v, input logic [4:0] aluc, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rsv, input logic [31:0] rtv,
                       input logic urs, input logic urt, input logic selsh,
                       input logic selimm, input logic [31:0] imm, input logic [4:0] sh,
                       input logic wreg, input logic m2r, input logic wmem);
    id_valid = v; id_aluc = aluc; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_val = rsv; id_rt_val = rtv; id_use_rs = urs; id_use_rt = urt;
    id_sel_shamt = selsh; id_sel_imm = selimm; id_imm = imm; id_shamt = sh;
    id_wreg = wreg; id_mem2reg = m2r; id_wmem = wmem;
  endtask

  task automatic srcs(input logic mw, input logic [4:0] mrd, input logic [31:0] mres,
                      input logic ww, input logic [4:0] wrd, input logic [31:0] wd);
    mem_wreg = mw; mem_rd = mrd; mem_res = mres;
    wb_wreg = ww; wb_rd = wrd; wb_data = wd;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    instr(0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    srcs(0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_valid", ex_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b0;

    // ADD r3,r1,r2
    instr(1, 5'b00000, 1, 2, 3, 5, 7, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    tick();
    chk("add_a", alu_a, 5); chk("add_b", alu_b, 7); chk("add_aluc", alu_aluc, 5'b00000);
    chk("add_valid", ex_valid, 1); chk("add_rd", ex_rd, 3);

    // ADD r7,r4,r0 with r4 in flight in both MEM and WB
    instr(1, 5'b00000, 4, 0, 7, 32'h99, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    tick();
    srcs(1, 4, 32'h10, 1, 4, 32'h20); #1;
    chk("fwd_mem_wins", alu_a, 32'h10);
    mem_wreg = 1'b0; #1;
    chk("fwd_wb", alu_a, 32'h20);
    srcs(0, 0, 0, 0, 0, 0);

    // LW r5,0(r1) followed by dependent ADD r6,r5,r1
    instr(1, 5'b00000, 1, 5, 5, 32'h100, 0, 1, 0, 0, 1, 0, 0, 1, 1, 0);
    tick();
    instr(1, 5'b00000, 5, 1, 6, 32'hDEAD, 32'h100, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("lu_stall", stall, 1);
    tick();
    chk("lu_bubble", ex_valid, 0); chk("lu_bubble_rd", ex_rd, 0); chk("lu_unstall", stall, 0);
    tick();
    srcs(0, 0, 0, 1, 5, 32'h55); #1;
    chk("replay_valid", ex_valid, 1); chk("replay_wb", alu_a, 32'h55); chk("replay_stall", stall, 0);
    srcs(0, 0, 0, 0, 0, 0);

    // Load-use coinciding with flush
    instr(1, 5'b00000, 1, 8, 8, 32'h40, 0, 1, 0, 0, 1, 4, 0, 1, 1, 0);
    tick();
    instr(1, 5'b00000, 8, 8, 9, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    flush = 1'b1; #1;
    chk("flush_stall", stall, 0);
    tick();
    flush = 1'b0;
    chk("flush_bubble", ex_valid, 0); chk("flush_wreg", ex_wreg, 0);

    // SLL r2,r3,4 then LUI
    instr(1, 5'b01010, 0, 3, 2, 0, 1, 0, 1, 1, 0, 0, 5'd4, 1, 0, 0);
    tick();
    chk("sll_a", alu_a, 4); chk("sll_b", alu_b, 1); chk("sll_aluc", alu_aluc, 5'b01010);
    instr(1, 5'b10000, 0, 9, 9, 0, 32'h77, 0, 0, 0, 1, 32'h1234, 0, 1, 0, 0);
    tick();
    chk("lui_b", alu_b, 32'h0000_1234); chk("lui_aluc", alu_aluc, 5'b10000);

    // LW r9, then reset while a dependent valid instruction sits in ID
    instr(1, 5'b00000, 1, 9, 9, 32'h8, 0, 1, 0, 0, 1, 0, 0, 1, 1, 0);
    tick();
    instr(1, 5'b00110, 9, 2, 10, 3, 4, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_valid", ex_valid, 0); chk("rst_mid_wreg", ex_wreg, 0);
    chk("rst_mid_m2r", ex_mem2reg, 0); chk("rst_mid_rd", ex_rd, 0);
    chk("rst_mid_aluc", alu_aluc, 0); chk("rst_mid_a", alu_a, 0);
    chk("rst_mid_b", alu_b, 0); chk("rst_mid_sd", ex_store_data, 0);

    // Reads of r0 are never forwarded
    instr(1, 5'b00000, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    tick();
    srcs(1, 0, 32'hFF, 1, 0, 32'hEE); #1;
    chk("r0_a", alu_a, 0); chk("r0_b", alu_b, 0);
    srcs(0, 0, 0, 0, 0, 0);

    // SW r7,8(r2): store data forwarded from MEM, ALU B takes the offset
    instr(1, 5'b00000, 2, 7, 0, 32'h200, 32'h11, 1, 1, 0, 1, 8, 0, 0, 0, 1);
    tick();
    srcs(1, 7, 32'hABCD, 0, 0, 0); #1;
    chk("sw_sd", ex_store_data, 32'hABCD); chk("sw_b", alu_b, 8);
    chk("sw_a", alu_a, 32'h200); chk("sw_wmem", ex_wmem, 1);
    srcs(0, 0, 0, 0, 0, 0);

    // Invalid decode slot becomes a bubble
    instr(0, 5'b00101, 3, 4, 5, 9, 9, 1, 1, 0, 1, 32'hFFFF, 0, 1, 0, 1);
    tick();
    chk("inv_valid", ex_valid, 0); chk("inv_b", alu_b, 0); chk("inv_wmem", ex_wmem, 0);

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
